// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: 8 blocks of 4 words, combinational hit path,
// single-block refill from instruction memory on a miss while BUSYWAIT stalls the CPU.
module icache_direct_mapped #(
   parameter int ADDR_WIDTH = 10,
   parameter int INDEX_BITS = 3
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [ADDR_WIDTH-1:0] ADDRESS,
   input  logic                  READ,
   output logic [31:0]           INSTRUCTION,
   output logic                  BUSYWAIT,
   output logic [ADDR_WIDTH-5:0] MEM_ADDRESS,
   output logic                  MEM_READ,
   input  logic [127:0]          MEM_READDATA,
   input  logic                  MEM_BUSYWAIT
);

   localparam int TAG_BITS = ADDR_WIDTH - 4 - INDEX_BITS;
   localparam int NBLK     = 1 << INDEX_BITS;

   typedef enum logic [1:0] {IDLE, FETCH, UPDATE} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-5:0]   miss_q, miss_d;
   logic                    mem_read_q, mem_read_d;
   logic [NBLK-1:0]         valid_q, valid_d;
   logic [TAG_BITS-1:0]     tag_q [NBLK];
   logic [127:0]            data_q [NBLK];

   logic [1:0]              offset;
   logic [INDEX_BITS-1:0]   index;
   logic [TAG_BITS-1:0]     tag;
   logic [INDEX_BITS-1:0]   miss_index;
   logic [TAG_BITS-1:0]     miss_tag;
   logic                    hit;
   logic                    fill_en;
   logic                    unused_addr_bits;

   assign offset           = ADDRESS[3:2];
   assign index            = ADDRESS[INDEX_BITS+3:4];
   assign tag              = ADDRESS[ADDR_WIDTH-1:INDEX_BITS+4];
   assign unused_addr_bits = ^ADDRESS[1:0];
   assign miss_index       = miss_q[INDEX_BITS-1:0];
   assign miss_tag         = miss_q[ADDR_WIDTH-5:INDEX_BITS];

   assign hit         = valid_q[index] && (tag_q[index] == tag);
   assign INSTRUCTION = hit ? data_q[index][{offset, 5'b0} +: 32] : 32'h0;
   assign BUSYWAIT    = READ && ((state_q != IDLE) || !hit);
   assign MEM_READ    = mem_read_q;
   // Address comes from the latched miss, so CPU address glitches cannot disturb the fill.
   assign MEM_ADDRESS = mem_read_q ? miss_q : '0;
   assign fill_en     = (state_q == FETCH) && !MEM_BUSYWAIT;

   always_comb begin
      state_d    = state_q;
      miss_d     = miss_q;
      mem_read_d = mem_read_q;
      valid_d    = valid_q;
      case (state_q)
         IDLE: begin
            if (READ && !hit) begin
               miss_d     = {tag, index};
               mem_read_d = 1'b1;
               state_d    = FETCH;
            end
         end
         FETCH: begin
            if (!MEM_BUSYWAIT) begin
               valid_d[miss_index] = 1'b1;
               mem_read_d          = 1'b0;
               state_d             = UPDATE;
            end
         end
         UPDATE: state_d = IDLE;
         default: begin
            mem_read_d = 1'b0;
            state_d    = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= IDLE;
         miss_q     <= '0;
         mem_read_q <= 1'b0;
         valid_q    <= '0;
      end else begin
         state_q    <= state_d;
         miss_q     <= miss_d;
         mem_read_q <= mem_read_d;
         valid_q    <= valid_d;
      end
   end

   // Payload arrays carry no reset; the valid bits alone gate their use.
   always_ff @(posedge CLK) begin
      if (fill_en) begin
         data_q[miss_index] <= MEM_READDATA;
         tag_q[miss_index]  <= miss_tag;
      end
   end

endmodule
